// File: rtl/spmm_lhs_encoder_pkg.sv
// Shared types and sizes for the SpMM LHS dense-to-CSR encoder.
package spmm_lhs_encoder_pkg;

  localparam int N     = 16;
  localparam int W     = 8;
  localparam int LGN   = $clog2(N);
  localparam int DBLGN = 2 * LGN;

  typedef logic [W-1:0]     data_t;
  typedef logic [LGN-1:0]   col_t;
  typedef logic [DBLGN-1:0] ptr_t;
  typedef logic [DBLGN:0]   nnz_t;
  typedef logic [LGN:0]     cnt_t;

  typedef struct packed {
    col_t  col;
    data_t data;
  } tile_slot_t;

  typedef tile_slot_t [N-1:0] tile_t;
  typedef data_t      [N-1:0] row_t;
  typedef ptr_t       [N-1:0] ptr_vec_t;
  typedef col_t       [N-1:0] col_vec_t;

  typedef enum logic [1:0] {COLLECT, FLUSH, SEND} enc_state_t;

endpackage

// File: rtl/spmm_lhs_encoder_if.sv
// Tile stream from the encoder (master) to the SpMM LHS port (slave).
interface spmm_lhs_encoder_if;
  import spmm_lhs_encoder_pkg::*;

  logic     lhs_ready;
  logic     lhs_start;
  logic     lhs_valid;
  logic     lhs_ws;
  logic     lhs_os;
  ptr_vec_t lhs_ptr;
  col_vec_t lhs_col;
  row_t     lhs_data;
  nnz_t     nnz;
  logic     done;

  modport master (
    input  lhs_ready,
    output lhs_start, lhs_valid, lhs_ws, lhs_os, lhs_ptr, lhs_col, lhs_data, nnz, done
  );

  modport slave (
    output lhs_ready,
    input  lhs_start, lhs_valid, lhs_ws, lhs_os, lhs_ptr, lhs_col, lhs_data, nnz, done
  );

endinterface

// File: rtl/spmm_lhs_encoder_row_compactor.sv
// Packs the nonzero elements of one dense row into the low slots, keeping column order.
module spmm_lhs_encoder_row_compactor
  import spmm_lhs_encoder_pkg::*;
(
  input  row_t  row_i,
  output tile_t slots_o,
  output cnt_t  count_o
);

  cnt_t pos;

  // Running prefix count of nonzeros gives each nonzero its destination slot.
  always_comb begin
    slots_o = '0;
    pos     = '0;
    for (int j = 0; j < N; j++) begin
      if (row_i[j] != '0) begin
        slots_o[pos[LGN-1:0]] = '{col: col_t'(j), data: row_i[j]};
        pos = pos + cnt_t'(1);
      end
    end
    count_o = pos;
  end

endmodule

// File: rtl/spmm_lhs_encoder.sv
// Dense-to-CSR encoder: collects N dense rows, packs nonzeros into N-wide tiles,
// then streams the tiles with row-start pointers to the SpMM LHS port.
module spmm_lhs_encoder
  import spmm_lhs_encoder_pkg::*;
(
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      in_valid_i,
  output logic                      in_ready_o,
  input  row_t                      in_row_i,
  spmm_lhs_encoder_if.master        lhs
);

  enc_state_t state_q, state_d;

  col_t       rowCnt_q;
  cnt_t       tileCnt_q;
  cnt_t       numTiles_q;
  cnt_t       sendIdx_q;
  cnt_t       stageCnt_q;
  tile_t      stage_q;
  nnz_t       nnzRun_q;
  nnz_t       nnz_q;
  ptr_vec_t   ptrRun_q;
  ptr_vec_t   ptr_q;
  logic       done_q;
  tile_t      tileMem_q [N];

  tile_t                  compSlots;
  cnt_t                   compCnt;
  tile_slot_t [2*N-1:0]   merged;
  cnt_t                   mergedCnt;
  cnt_t                   mergeIdx;
  logic                   tileFull;
  logic                   rowAccept;
  logic                   tileAccept;
  logic                   lastTile;
  logic                   flushWrite;
  tile_t                  curTile;

  spmm_lhs_encoder_row_compactor u_compactor (
    .row_i   (in_row_i),
    .slots_o (compSlots),
    .count_o (compCnt)
  );

  // Handshake decodes shared by the FSM and the datapath.
  always_comb begin
    rowAccept  = in_valid_i && (state_q == COLLECT);
    tileAccept = (state_q == SEND) && lhs.lhs_ready;
    lastTile   = (sendIdx_q == numTiles_q - cnt_t'(1));
    flushWrite = (stageCnt_q != '0) || (tileCnt_q == '0);
  end

  // Append the freshly compacted row behind whatever is already staged.
  always_comb begin
    merged        = '0;
    merged[N-1:0] = stage_q;
    mergeIdx      = '0;
    for (int i = 0; i < N; i++) begin
      if (cnt_t'(i) < compCnt) begin
        mergeIdx         = stageCnt_q + cnt_t'(i);
        merged[mergeIdx] = compSlots[i];
      end
    end
    mergedCnt = stageCnt_q + compCnt;
    tileFull  = (mergedCnt >= cnt_t'(N));
  end

  // State register; reset aborts any transfer in progress.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= COLLECT;
    else       state_q <= state_d;
  end

  // Next-state: collect N rows, one flush cycle, then stream until the last tile leaves.
  always_comb begin
    state_d = state_q;
    case (state_q)
      COLLECT: if (rowAccept && (rowCnt_q == col_t'(N-1))) state_d = FLUSH;
      FLUSH:   state_d = SEND;
      SEND:    if (tileAccept && lastTile) state_d = COLLECT;
      default: state_d = COLLECT;
    endcase
  end

  // Outputs; tile data is gated to zero outside SEND since memory is undefined after reset.
  always_comb begin
    curTile        = tileMem_q[sendIdx_q[LGN-1:0]];
    in_ready_o     = (state_q == COLLECT) && !reset;
    lhs.lhs_valid  = tileAccept;
    lhs.lhs_start  = tileAccept && (sendIdx_q == '0);
    lhs.lhs_ws     = 1'b0;
    lhs.lhs_os     = 1'b0;
    lhs.lhs_ptr    = ptr_q;
    lhs.nnz        = nnz_q;
    lhs.done       = done_q;
    lhs.lhs_col    = '0;
    lhs.lhs_data   = '0;
    if (state_q == SEND) begin
      for (int i = 0; i < N; i++) begin
        lhs.lhs_col[i]  = curTile[i].col;
        lhs.lhs_data[i] = curTile[i].data;
      end
    end
  end

  // Counters, staging buffer and pointer registers; published ptr/nnz change only at flush.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rowCnt_q   <= '0;
      tileCnt_q  <= '0;
      numTiles_q <= '0;
      sendIdx_q  <= '0;
      stageCnt_q <= '0;
      stage_q    <= '0;
      nnzRun_q   <= '0;
      nnz_q      <= '0;
      ptrRun_q   <= '0;
      ptr_q      <= '0;
      done_q     <= 1'b0;
    end else begin
      done_q <= tileAccept && lastTile;
      case (state_q)
        COLLECT: begin
          if (rowAccept) begin
            ptrRun_q[rowCnt_q] <= nnzRun_q[DBLGN-1:0];
            nnzRun_q           <= nnzRun_q + nnz_t'(compCnt);
            rowCnt_q           <= rowCnt_q + col_t'(1);
            if (tileFull) begin
              tileCnt_q  <= tileCnt_q + cnt_t'(1);
              stage_q    <= merged[2*N-1:N];
              stageCnt_q <= mergedCnt - cnt_t'(N);
            end else begin
              stage_q    <= merged[N-1:0];
              stageCnt_q <= mergedCnt;
            end
          end
        end
        FLUSH: begin
          numTiles_q <= flushWrite ? tileCnt_q + cnt_t'(1) : tileCnt_q;
          nnz_q      <= nnzRun_q;
          ptr_q      <= ptrRun_q;
          nnzRun_q   <= '0;
          tileCnt_q  <= '0;
          stage_q    <= '0;
          stageCnt_q <= '0;
          sendIdx_q  <= '0;
        end
        SEND: begin
          if (tileAccept) sendIdx_q <= lastTile ? '0 : sendIdx_q + cnt_t'(1);
        end
        default: ;
      endcase
    end
  end

  // Tile memory: full tiles written during collection, the padded remainder at flush.
  always_ff @(posedge clock) begin
    if (rowAccept && tileFull) begin
      tileMem_q[tileCnt_q[LGN-1:0]] <= merged[N-1:0];
    end else if ((state_q == FLUSH) && flushWrite) begin
      tileMem_q[tileCnt_q[LGN-1:0]] <= stage_q;
    end
  end

endmodule

// File: tb/tb_spmm_lhs_encoder.sv
// Scoreboard bench for spmm_lhs_encoder: a matrix-level CSR model predicts every tile.
module tb_spmm_lhs_encoder;
  import spmm_lhs_encoder_pkg::*;

  typedef struct {
    logic [N-1:0][LGN-1:0]   col;
    logic [N-1:0][W-1:0]     data;
    logic                    start;
    logic                    last;
    logic [N-1:0][DBLGN-1:0] ptr;
    logic [DBLGN:0]          nnz;
  } expTile_t;

  logic                  clock = 1'b0;
  logic                  reset;
  logic                  inValid;
  logic                  inReady;
  logic [N-1:0][W-1:0]   inRow;

  spmm_lhs_encoder_if lhsIf();

  spmm_lhs_encoder dut (
    .clock      (clock),
    .reset      (reset),
    .in_valid_i (inValid),
    .in_ready_o (inReady),
    .in_row_i   (inRow),
    .lhs        (lhsIf)
  );

  always #5 clock = ~clock;

  logic [W-1:0] mat [N][N];
  expTile_t     sbQ[$];
  int           total = 0;
  int           bad = 0;
  int           tilesSeen = 0;
  int           readyMode = 0;
  bit           stallWatch = 0;
  bit           expDone = 0;

  task automatic checkOutput(input string name, input logic [511:0] act, input logic [511:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Matrix-level model: list nonzeros row-major, cut the list into N-wide tiles.
  task automatic pushExpected();
    logic [LGN-1:0]          colQ[$];
    logic [W-1:0]            datQ[$];
    logic [N-1:0][DBLGN-1:0] ptrs;
    expTile_t                e;
    int                      nz = 0;
    int                      nt;
    for (int r = 0; r < N; r++) begin
      ptrs[r] = DBLGN'(nz);
      for (int c = 0; c < N; c++) begin
        if (mat[r][c] != 0) begin
          colQ.push_back(LGN'(c));
          datQ.push_back(mat[r][c]);
          nz++;
        end
      end
    end
    nt = (nz == 0) ? 1 : (nz + N - 1) / N;
    for (int t = 0; t < nt; t++) begin
      e.col  = '0;
      e.data = '0;
      for (int i = 0; i < N; i++) begin
        if (t * N + i < nz) begin
          e.col[i]  = colQ[t * N + i];
          e.data[i] = datQ[t * N + i];
        end
      end
      e.start = (t == 0);
      e.last  = (t == nt - 1);
      e.ptr   = ptrs;
      e.nnz   = (DBLGN+1)'(nz);
      sbQ.push_back(e);
    end
  endtask

  task automatic fillMatrix(input int kind, input int dens);
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        case (kind)
          0: mat[r][c] = (r == c) ? 8'd1 : 8'd0;
          1: mat[r][c] = 8'd0;
          2: mat[r][c] = 8'd1;
          3: mat[r][c] = (r < 3 && c < 6) ? W'($urandom_range(1, 255)) : 8'd0;
          default: mat[r][c] = ($urandom_range(0, 99) < dens) ? W'($urandom_range(1, 255)) : 8'd0;
        endcase
      end
    end
  endtask

  // Feed the N rows; optionally check the flush cycle and keep in_valid high afterwards.
  task automatic applyStimulus(input bit latChk, input bit holdValid);
    pushExpected();
    for (int r = 0; r < N; r++) begin
      @(negedge clock);
      checkOutput("in_ready_collect", inReady, 1);
      inValid = 1'b1;
      for (int c = 0; c < N; c++) inRow[c] = mat[r][c];
      @(posedge clock);
    end
    @(negedge clock);
    if (latChk) begin
      checkOutput("flush_in_ready", inReady, 0);
      checkOutput("flush_valid", lhsIf.lhs_valid, 0);
    end
    inValid = holdValid;
    inRow   = {N{W'($urandom_range(1, 255))}};
  endtask

  task automatic waitDone();
    int k;
    for (k = 0; k < 400; k++) begin
      @(negedge clock);
      if (lhsIf.done) break;
    end
    inValid = 1'b0;
    if (k == 400) begin
      total++;
      bad++;
      $display("[TB] FAIL done_timeout: actual=no done required=done pulse");
    end
    checkOutput("queue_drained", sbQ.size(), 0);
  endtask

  // lhs_ready driver, changed just after the active edge.
  always @(posedge clock) begin
    #1;
    case (readyMode)
      0: lhsIf.lhs_ready = 1'b1;
      1: lhsIf.lhs_ready = ($urandom_range(0, 3) != 0);
      default: ;
    endcase
  end

  // Monitor: pops the scoreboard whenever a tile is presented and checks done timing.
  always @(negedge clock) begin
    if (reset) begin
      expDone = 1'b0;
    end else begin
      if (expDone || lhsIf.done) begin
        checkOutput("done_pulse", lhsIf.done, expDone);
        expDone = 1'b0;
      end
      if (stallWatch && !lhsIf.lhs_ready) begin
        checkOutput("stall_valid", lhsIf.lhs_valid, 0);
        if (sbQ.size() > 0) begin
          checkOutput("stall_col", lhsIf.lhs_col, sbQ[0].col);
          checkOutput("stall_data", lhsIf.lhs_data, sbQ[0].data);
        end
      end
      if (lhsIf.lhs_valid) begin
        if (sbQ.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpected_tile: actual=extra tile required=none");
        end else begin
          expTile_t e;
          e = sbQ.pop_front();
          checkOutput("tile_col", lhsIf.lhs_col, e.col);
          checkOutput("tile_data", lhsIf.lhs_data, e.data);
          checkOutput("tile_start", lhsIf.lhs_start, e.start);
          checkOutput("tile_ptr", lhsIf.lhs_ptr, e.ptr);
          checkOutput("tile_nnz", lhsIf.nnz, e.nnz);
          checkOutput("ws_os", {lhsIf.lhs_ws, lhsIf.lhs_os}, 0);
          tilesSeen++;
          if (e.last) expDone = 1'b1;
        end
      end
    end
  end

  task automatic checkIdle(input string tag);
    checkOutput({tag, "_valid"}, lhsIf.lhs_valid, 0);
    checkOutput({tag, "_start"}, lhsIf.lhs_start, 0);
    checkOutput({tag, "_col"}, lhsIf.lhs_col, 0);
    checkOutput({tag, "_data"}, lhsIf.lhs_data, 0);
    checkOutput({tag, "_ptr"}, lhsIf.lhs_ptr, 0);
    checkOutput({tag, "_nnz"}, lhsIf.nnz, 0);
    checkOutput({tag, "_done"}, lhsIf.done, 0);
  endtask

  task automatic identityRun(input string tag);
    fillMatrix(0, 0);
    applyStimulus(1, 0);
    @(negedge clock);
    checkOutput({tag, "_first_start"}, lhsIf.lhs_start, 1);
    waitDone();
    checkOutput({tag, "_nnz"}, lhsIf.nnz, 16);
    checkOutput({tag, "_ptr15"}, lhsIf.lhs_ptr[15], 15);
  endtask

  initial begin
    int base;
    reset             = 1'b1;
    inValid           = 1'b0;
    inRow             = '0;
    lhsIf.lhs_ready   = 1'b1;
    repeat (3) @(negedge clock);
    checkIdle("reset");
    reset = 1'b0;
    #1;
    checkOutput("in_ready_after_reset", inReady, 1);

    $display("[TB] identity matrix");
    identityRun("ident");

    $display("[TB] all-zero matrix");
    fillMatrix(1, 0);
    applyStimulus(0, 0);
    waitDone();
    checkOutput("zero_nnz", lhsIf.nnz, 0);
    checkOutput("zero_ptr", lhsIf.lhs_ptr, 0);

    $display("[TB] all-ones matrix");
    fillMatrix(2, 0);
    applyStimulus(0, 1);
    waitDone();
    checkOutput("ones_nnz", lhsIf.nnz, 256);
    checkOutput("ones_ptr15", lhsIf.lhs_ptr[15], 240);

    $display("[TB] three short rows straddling a tile");
    fillMatrix(3, 0);
    applyStimulus(0, 0);
    waitDone();
    checkOutput("short_ptr1", lhsIf.lhs_ptr[1], 6);
    checkOutput("short_ptr2", lhsIf.lhs_ptr[2], 12);
    checkOutput("short_ptr15", lhsIf.lhs_ptr[15], 18);

    $display("[TB] dense matrix with stall after tile 2");
    readyMode = 2;
    lhsIf.lhs_ready = 1'b1;
    fillMatrix(4, 100);
    base = tilesSeen;
    applyStimulus(0, 0);
    for (int k = 0; k < 200; k++) begin
      @(posedge clock);
      #1;
      if (tilesSeen >= base + 3) break;
    end
    lhsIf.lhs_ready = 1'b0;
    stallWatch = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    lhsIf.lhs_ready = 1'b1;
    stallWatch = 1'b0;
    waitDone();
    readyMode = 0;

    $display("[TB] reset during transfer");
    fillMatrix(4, 100);
    base = tilesSeen;
    applyStimulus(0, 0);
    for (int k = 0; k < 200; k++) begin
      @(posedge clock);
      #1;
      if (tilesSeen >= base + 5) break;
    end
    #2;
    reset = 1'b1;
    #1;
    checkIdle("midreset");
    sbQ.delete();
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    #1;
    checkOutput("in_ready_after_abort", inReady, 1);
    identityRun("ident2");

    $display("[TB] random matrices with random lhs_ready");
    readyMode = 1;
    for (int m = 0; m < 6; m++) begin
      fillMatrix(4, $urandom_range(0, 100));
      applyStimulus(0, 1);
      waitDone();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
